// File: rtl/conv2d_pass_scheduler.sv
// Pass sequencer for the PE-with-buffers block: walks output channel, input
// channel, row and column, and emits the kernel/row/channel strobes the PE control unit consumes.
module conv2d_pass_scheduler #(
    parameter int IMG_W_MAX = 256,
    parameter int CH_BITS   = 10,
    parameter int ROW_BITS  = 8,
    localparam int COL_BITS = $clog2(IMG_W_MAX)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [CH_BITS-1:0]  cfg_in_ch_i,
    input  logic [CH_BITS-1:0]  cfg_out_ch_i,
    input  logic [ROW_BITS-1:0] cfg_rows_i,
    input  logic [COL_BITS-1:0] cfg_cols_i,
    input  logic                kernel_valid_i,
    input  logic                pix_valid_i,
    output logic                pix_ready_o,
    input  logic                PE_ready_i,
    input  logic                PE_with_buffers_IDLE_i,
    output logic                Load_kernel_reg_o,
    output logic                Stream_mid_row_o,
    output logic                Stream_last_row_o,
    output logic                Output_valid_o,
    output logic [COL_BITS-1:0] b_counter_output_o,
    output logic                Done_1row_o,
    output logic                last_channel_o,
    output logic [CH_BITS-1:0]  cur_oc_o,
    output logic [CH_BITS-1:0]  cur_ic_o,
    output logic                busy_o,
    output logic                done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_K,
        S_ROW_WAIT,
        S_STREAM,
        S_ROW_END,
        S_DRAIN
    } state_e;

    localparam logic [CH_BITS-1:0]  CH_ONE  = CH_BITS'(1);
    localparam logic [ROW_BITS-1:0] ROW_ONE = ROW_BITS'(1);

    state_e state_q, state_d;

    logic [CH_BITS-1:0]  cfg_in_ch_q, cfg_in_ch_d;
    logic [CH_BITS-1:0]  cfg_out_ch_q, cfg_out_ch_d;
    logic [ROW_BITS-1:0] cfg_rows_q, cfg_rows_d;
    logic [COL_BITS-1:0] cfg_cols_q, cfg_cols_d;

    logic [CH_BITS-1:0]  oc_q, oc_d;
    logic [CH_BITS-1:0]  ic_q, ic_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [COL_BITS-1:0] col_q, col_d;

    logic                load_k_q, load_k_d;
    logic                stream_mid_q, stream_mid_d;
    logic                stream_last_q, stream_last_d;
    logic                out_valid_q, out_valid_d;
    logic [COL_BITS-1:0] b_cnt_q, b_cnt_d;
    logic                done_1row_q, done_1row_d;
    logic                last_ch_q, last_ch_d;
    logic                done_q, done_d;

    logic accept;
    logic is_last_row;
    logic is_last_ic;
    logic is_last_oc;
    logic stream_active;

    assign accept      = pix_valid_i && (state_q == S_STREAM);
    assign is_last_row = (row_q == cfg_rows_q - ROW_ONE);
    assign is_last_ic  = (ic_q == cfg_in_ch_q - CH_ONE);
    assign is_last_oc  = (oc_q == cfg_out_ch_q - CH_ONE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cfg_in_ch_d  = cfg_in_ch_q;
        cfg_out_ch_d = cfg_out_ch_q;
        cfg_rows_d   = cfg_rows_q;
        cfg_cols_d   = cfg_cols_q;
        oc_d         = oc_q;
        ic_d         = ic_q;
        row_d        = row_q;
        col_d        = col_q;
        load_k_d     = 1'b0;
        done_1row_d  = 1'b0;
        done_d       = 1'b0;
        out_valid_d  = accept;
        b_cnt_d      = accept ? col_q : b_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d      = S_LOAD_K;
                    cfg_in_ch_d  = cfg_in_ch_i;
                    cfg_out_ch_d = cfg_out_ch_i;
                    cfg_rows_d   = cfg_rows_i;
                    cfg_cols_d   = cfg_cols_i;
                    oc_d         = '0;
                    ic_d         = '0;
                    row_d        = '0;
                    col_d        = '0;
                end
            end
            S_LOAD_K: begin
                if (kernel_valid_i) begin
                    state_d  = S_ROW_WAIT;
                    load_k_d = 1'b1;
                end
            end
            S_ROW_WAIT: begin
                if (PE_ready_i) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                // The final column is held rather than stepped past, so the
                // counter never leaves 0..cfg_cols.
                if (accept) begin
                    if (col_q == cfg_cols_q) begin
                        state_d = S_ROW_END;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_ROW_END: begin
                done_1row_d = 1'b1;
                col_d       = '0;
                if (!is_last_row) begin
                    row_d   = row_q + 1'b1;
                    state_d = S_ROW_WAIT;
                end else begin
                    row_d = '0;
                    if (!is_last_ic) begin
                        ic_d    = ic_q + 1'b1;
                        state_d = S_LOAD_K;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (PE_with_buffers_IDLE_i) begin
                    if (is_last_oc) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        oc_d    = oc_q + 1'b1;
                        ic_d    = '0;
                        state_d = S_LOAD_K;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Row flags cover the row from the first STREAM cycle through ROW_END;
        // row_q is stable across that whole window.
        stream_active = (state_d == S_STREAM) || (state_d == S_ROW_END);
        stream_mid_d  = stream_active && !is_last_row;
        stream_last_d = stream_active && is_last_row;

        // One-cycle lag on ic keeps the flag valid for the Done_1row that
        // trails the channel's last row; the start case avoids a low blip
        // on the first LOAD_K cycle.
        if (state_q == S_IDLE) begin
            last_ch_d = start_i && (cfg_in_ch_i == CH_ONE);
        end else begin
            last_ch_d = is_last_ic;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_in_ch_q   <= '0;
            cfg_out_ch_q  <= '0;
            cfg_rows_q    <= '0;
            cfg_cols_q    <= '0;
            oc_q          <= '0;
            ic_q          <= '0;
            row_q         <= '0;
            col_q         <= '0;
            load_k_q      <= 1'b0;
            stream_mid_q  <= 1'b0;
            stream_last_q <= 1'b0;
            out_valid_q   <= 1'b0;
            b_cnt_q       <= '0;
            done_1row_q   <= 1'b0;
            last_ch_q     <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            cfg_in_ch_q   <= cfg_in_ch_d;
            cfg_out_ch_q  <= cfg_out_ch_d;
            cfg_rows_q    <= cfg_rows_d;
            cfg_cols_q    <= cfg_cols_d;
            oc_q          <= oc_d;
            ic_q          <= ic_d;
            row_q         <= row_d;
            col_q         <= col_d;
            load_k_q      <= load_k_d;
            stream_mid_q  <= stream_mid_d;
            stream_last_q <= stream_last_d;
            out_valid_q   <= out_valid_d;
            b_cnt_q       <= b_cnt_d;
            done_1row_q   <= done_1row_d;
            last_ch_q     <= last_ch_d;
            done_q        <= done_d;
        end
    end

    assign pix_ready_o        = (state_q == S_STREAM);
    assign busy_o             = (state_q != S_IDLE);
    assign Load_kernel_reg_o  = load_k_q;
    assign Stream_mid_row_o   = stream_mid_q;
    assign Stream_last_row_o  = stream_last_q;
    assign Output_valid_o     = out_valid_q;
    assign b_counter_output_o = b_cnt_q;
    assign Done_1row_o        = done_1row_q;
    assign last_channel_o     = last_ch_q;
    assign cur_oc_o           = oc_q;
    assign cur_ic_o           = ic_q;
    assign done_o             = done_q;

endmodule

// File: tb/tb_conv2d_pass_scheduler.sv
// Directed bench for conv2d_pass_scheduler: a negedge monitor tallies strobes,
// the main sequence drives each scenario and compares tallies to hand-computed counts.
module tb_conv2d_pass_scheduler;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [9:0] cfg_in_ch;
    logic [9:0] cfg_out_ch;
    logic [7:0] cfg_rows;
    logic [7:0] cfg_cols;
    logic       kernel_valid;
    logic       pix_valid;
    logic       pix_ready;
    logic       PE_ready;
    logic       PE_with_buffers_IDLE;
    logic       Load_kernel_reg;
    logic       Stream_mid_row;
    logic       Stream_last_row;
    logic       Output_valid;
    logic [7:0] b_counter_output;
    logic       Done_1row;
    logic       last_channel;
    logic [9:0] cur_oc;
    logic [9:0] cur_ic;
    logic       busy;
    logic       done;

    conv2d_pass_scheduler dut (
        .clk_i                  (clk),
        .rst_ni                 (rst_n),
        .start_i                (start),
        .cfg_in_ch_i            (cfg_in_ch),
        .cfg_out_ch_i           (cfg_out_ch),
        .cfg_rows_i             (cfg_rows),
        .cfg_cols_i             (cfg_cols),
        .kernel_valid_i         (kernel_valid),
        .pix_valid_i            (pix_valid),
        .pix_ready_o            (pix_ready),
        .PE_ready_i             (PE_ready),
        .PE_with_buffers_IDLE_i (PE_with_buffers_IDLE),
        .Load_kernel_reg_o      (Load_kernel_reg),
        .Stream_mid_row_o       (Stream_mid_row),
        .Stream_last_row_o      (Stream_last_row),
        .Output_valid_o         (Output_valid),
        .b_counter_output_o     (b_counter_output),
        .Done_1row_o            (Done_1row),
        .last_channel_o         (last_channel),
        .cur_oc_o               (cur_oc),
        .cur_ic_o               (cur_ic),
        .busy_o                 (busy),
        .done_o                 (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Monitor tallies, written only by the monitor process.
    int n_load = 0, n_ov = 0, n_d1r = 0, n_done = 0, n_mid = 0, n_last = 0;
    int n_last_ov = 0, n_lc_ov = 0, n_lc_d1r = 0, n_pr = 0, n_bb = 0, n_bad = 0;
    logic [7:0] ov_log[$];
    logic [9:0] lc_ref_ic = 10'd0;
    logic [7:0] ref_cols = 8'd0;
    logic       pv_toggle = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        logic       prev_ov;
        logic [7:0] prev_idx;
        prev_ov  = 1'b0;
        prev_idx = 8'd0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (Load_kernel_reg) n_load++;
                if (Output_valid) begin
                    n_ov++;
                    ov_log.push_back(b_counter_output);
                    if (prev_ov) n_bb++;
                    if (Stream_last_row) n_last_ov++;
                    if (last_channel) n_lc_ov++;
                    if (last_channel != (cur_ic == lc_ref_ic)) n_bad++;
                    if (!(Stream_mid_row ^ Stream_last_row)) n_bad++;
                end
                if (Done_1row) begin
                    n_d1r++;
                    if (last_channel) n_lc_d1r++;
                    if (!prev_ov || prev_idx != ref_cols) n_bad++;
                end
                if (Stream_mid_row && Stream_last_row) n_bad++;
                if (done) begin
                    n_done++;
                    if (busy) n_bad++;
                end
                if (pix_ready) n_pr++;
                if (Stream_mid_row) n_mid++;
                if (Stream_last_row) n_last++;
                prev_ov  = Output_valid;
                prev_idx = b_counter_output;
            end else begin
                prev_ov = 1'b0;
            end
        end
    end

    // Upstream window source: always valid, or toggling every cycle.
    initial begin
        pix_valid = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            pix_valid = pv_toggle ? ~pix_valid : 1'b1;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic run_start(input int ic_n, input int oc_n, input int rows, input int cols);
        cfg_in_ch  = 10'(ic_n);
        cfg_out_ch = 10'(oc_n);
        cfg_rows   = 8'(rows);
        cfg_cols   = 8'(cols);
        lc_ref_ic  = 10'(ic_n - 1);
        ref_cols   = 8'(cols);
        start      = 1'b1;
        tick();
        start      = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    function automatic int cnt(input int which);
        case (which)
            0:       return n_ov;
            1:       return n_d1r;
            default: return n_done;
        endcase
    endfunction

    task automatic wait_cnt(input int which, input int target, input string tag);
        int k;
        k = 0;
        while (cnt(which) < target && k < 4000) begin
            tick();
            k++;
        end
        check(tag, 32'(cnt(which) >= target), 32'd1);
    endtask

    task automatic check_idx(input int base, input int cols, input string tag);
        int bad;
        bad = 0;
        for (int i = base; i < ov_log.size(); i++) begin
            if (int'(ov_log[i]) != (i - base) % (cols + 1)) bad++;
        end
        check(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        int b_load, b_ov, b_d1r, b_done, b_mid, b_last, b_lov, b_lcov, b_lcd, b_pr, b_bb, b_bad;

        rst_n                = 1'b0;
        start                = 1'b0;
        cfg_in_ch            = 10'd1;
        cfg_out_ch           = 10'd1;
        cfg_rows             = 8'd2;
        cfg_cols             = 8'd1;
        kernel_valid         = 1'b1;
        PE_ready             = 1'b1;
        PE_with_buffers_IDLE = 1'b1;

        // Reset state
        tick(2);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pix_ready", 32'(pix_ready), 32'd0);
        check("rst_load_k", 32'(Load_kernel_reg), 32'd0);
        check("rst_ov", 32'(Output_valid), 32'd0);
        check("rst_flags", 32'({Stream_mid_row, Stream_last_row, Done_1row, last_channel, done}), 32'd0);
        check("rst_idx", 32'({cur_oc, cur_ic, b_counter_output}), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Test 1: asynchronous reset mid-STREAM at row 2, column 1
        b_ov = n_ov;
        run_start(2, 1, 4, 3);
        wait_cnt(0, b_ov + 10, "t1_reach_row2");
        check("t1_pre_idx", 32'(b_counter_output), 32'd1);
        check("t1_pre_mid", 32'(Stream_mid_row), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t1_rst_busy", 32'(busy), 32'd0);
        check("t1_rst_pr", 32'(pix_ready), 32'd0);
        check("t1_rst_ov", 32'(Output_valid), 32'd0);
        check("t1_rst_idx", 32'(b_counter_output), 32'd0);
        check("t1_rst_mid", 32'(Stream_mid_row), 32'd0);
        tick(3);
        rst_n = 1'b1;
        b_load = n_load;
        b_pr   = n_pr;
        tick(5);
        check("t1_quiet_load", 32'(n_load - b_load), 32'd0);
        check("t1_quiet_pr", 32'(n_pr - b_pr), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);
        $display("test 1: reset mid-stream done at %0t", $time);

        // Test 2: single pass, 1 ic, 1 oc, 3 rows x 4 cols
        b_load = n_load; b_ov = n_ov; b_d1r = n_d1r; b_done = n_done; b_mid = n_mid;
        b_last = n_last; b_lov = n_last_ov; b_lcov = n_lc_ov; b_lcd = n_lc_d1r;
        b_pr = n_pr; b_bb = n_bb; b_bad = n_bad;
        run_start(1, 1, 3, 3);
        wait_cnt(2, b_done + 1, "t2_done_seen");
        check("t2_loads", 32'(n_load - b_load), 32'd1);
        check("t2_ov", 32'(n_ov - b_ov), 32'd12);
        check_idx(b_ov, 3, "t2_idx_seq");
        check("t2_d1r", 32'(n_d1r - b_d1r), 32'd3);
        check("t2_mid_cycles", 32'(n_mid - b_mid), 32'd10);
        check("t2_last_cycles", 32'(n_last - b_last), 32'd5);
        check("t2_last_ov", 32'(n_last_ov - b_lov), 32'd4);
        check("t2_lc_ov", 32'(n_lc_ov - b_lcov), 32'd12);
        check("t2_lc_d1r", 32'(n_lc_d1r - b_lcd), 32'd3);
        check("t2_pr_cycles", 32'(n_pr - b_pr), 32'd12);
        check("t2_backtoback", 32'(n_bb - b_bb), 32'd9);
        check("t2_rules", 32'(n_bad - b_bad), 32'd0);
        check("t2_ch_idx", 32'({cur_oc, cur_ic}), 32'd0);
        tick(3);
        check("t2_single_done", 32'(n_done - b_done), 32'd1);
        $display("test 2: single pass done at %0t", $time);

        // Test 3: 3 ic x 2 oc, 2x2 image, DRAIN held 10 cycles
        b_load = n_load; b_ov = n_ov; b_d1r = n_d1r; b_done = n_done;
        b_lcov = n_lc_ov; b_lcd = n_lc_d1r; b_bad = n_bad;
        PE_with_buffers_IDLE = 1'b0;
        run_start(3, 2, 2, 1);
        wait_cnt(1, b_d1r + 6, "t3_reach_drain");
        tick(10);
        check("t3_drain_oc", 32'(cur_oc), 32'd0);
        check("t3_drain_busy", 32'(busy), 32'd1);
        check("t3_drain_loads", 32'(n_load - b_load), 32'd3);
        PE_with_buffers_IDLE = 1'b1;
        tick();
        check("t3_oc_adv", 32'({cur_oc, cur_ic}), 32'({10'd1, 10'd0}));
        wait_cnt(2, b_done + 1, "t3_done_seen");
        check("t3_loads", 32'(n_load - b_load), 32'd6);
        check("t3_ov", 32'(n_ov - b_ov), 32'd24);
        check_idx(b_ov, 1, "t3_idx_seq");
        check("t3_d1r", 32'(n_d1r - b_d1r), 32'd12);
        check("t3_lc_ov", 32'(n_lc_ov - b_lcov), 32'd8);
        check("t3_lc_d1r", 32'(n_lc_d1r - b_lcd), 32'd4);
        check("t3_rules", 32'(n_bad - b_bad), 32'd0);
        check("t3_final_ch", 32'({cur_oc, cur_ic}), 32'({10'd1, 10'd2}));
        $display("test 3: multi-channel pass done at %0t", $time);

        // Test 4: pix_valid toggling, 2 rows x 4 cols
        b_ov = n_ov; b_d1r = n_d1r; b_done = n_done; b_bb = n_bb; b_bad = n_bad;
        pv_toggle = 1'b1;
        run_start(1, 1, 2, 3);
        wait_cnt(2, b_done + 1, "t4_done_seen");
        pv_toggle = 1'b0;
        check("t4_ov", 32'(n_ov - b_ov), 32'd8);
        check_idx(b_ov, 3, "t4_idx_seq");
        check("t4_gaps", 32'(n_bb - b_bb), 32'd0);
        check("t4_d1r", 32'(n_d1r - b_d1r), 32'd2);
        check("t4_rules", 32'(n_bad - b_bad), 32'd0);
        $display("test 4: throttled pass done at %0t", $time);

        // Test 5: kernel_valid low 3 cycles, PE_ready low 5 cycles
        b_load = n_load; b_ov = n_ov; b_done = n_done; b_pr = n_pr;
        kernel_valid = 1'b0;
        PE_ready     = 1'b0;
        run_start(1, 1, 2, 1);
        tick(3);
        check("t5_no_load", 32'(n_load - b_load), 32'd0);
        check("t5_load_low", 32'(Load_kernel_reg), 32'd0);
        kernel_valid = 1'b1;
        tick();
        check("t5_load_pulse", 32'(Load_kernel_reg), 32'd1);
        tick();
        check("t5_load_width", 32'(Load_kernel_reg), 32'd0);
        tick(4);
        check("t5_no_ready", 32'(n_pr - b_pr), 32'd0);
        check("t5_no_stream", 32'(Stream_mid_row), 32'd0);
        PE_ready = 1'b1;
        tick();
        check("t5_ready_go", 32'(pix_ready), 32'd1);
        wait_cnt(2, b_done + 1, "t5_done_seen");
        check("t5_ov", 32'(n_ov - b_ov), 32'd4);
        check("t5_loads", 32'(n_load - b_load), 32'd1);
        $display("test 5: stalled pass done at %0t", $time);

        // Test 6: start pulsed while busy with different config
        b_load = n_load; b_ov = n_ov; b_d1r = n_d1r; b_done = n_done;
        run_start(2, 2, 2, 1);
        wait_cnt(1, b_d1r + 2, "t6_reach_ic1");
        cfg_in_ch  = 10'd1;
        cfg_out_ch = 10'd1;
        cfg_rows   = 8'd3;
        cfg_cols   = 8'd2;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        check("t6_ch_kept", 32'({cur_oc, cur_ic}), 32'({10'd0, 10'd1}));
        wait_cnt(2, b_done + 1, "t6_done_seen");
        check("t6_loads", 32'(n_load - b_load), 32'd4);
        check("t6_ov", 32'(n_ov - b_ov), 32'd16);
        check("t6_d1r", 32'(n_d1r - b_d1r), 32'd8);
        tick(20);
        check("t6_one_done", 32'(n_done - b_done), 32'd1);
        check("t6_idle", 32'(busy), 32'd0);
        $display("test 6: ignored-start pass done at %0t", $time);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
